// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use / branch-operand stall detection, IF/ID flush,
// multi-cycle mul/div busy window and saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             branch_taken,
    input  logic             id_muldiv_start,
    input  logic             id_reads_hilo,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_mem_read,
    output logic             freeze,
    output logic             IF_Flush,
    output logic             id_ex_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    typedef enum logic {IDLE, MD_BUSY} state_t;

    state_t           state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use, br_stall, md_stall, stall;

    // Register 0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic urs,
                                       input logic urt);
        return (r != 5'd0) && ((urs && (r == rs)) || (urt && (r == rt)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (!en || (v == '1)) return v;
        return v + CNT_W'(1);
    endfunction

    always_comb begin
        load_use = ex_mem_read && reg_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);
        br_stall = id_branch &&
                   ((ex_reg_write && reg_match(ex_rd, id_rs, id_rt, id_uses_rs, id_uses_rt)) ||
                    (mem_mem_read && reg_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt)));
        md_stall = md_busy && (id_reads_hilo || id_muldiv_start);
        stall    = load_use || br_stall || md_stall;
    end

    assign md_busy      = (state_q == MD_BUSY);
    assign md_done      = md_busy && (md_cnt_q == 8'd0) && !reset;
    assign freeze       = stall && !reset;
    assign id_ex_bubble = stall && !reset;
    // A taken branch that is still stalled flushes only on its resolution cycle.
    assign IF_Flush     = id_branch && branch_taken && !stall && !reset;

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        stall_cycles_d = sat_inc(stall_cycles_q, freeze);
        flush_count_d  = sat_inc(flush_count_q, IF_Flush);
        case (state_q)
            IDLE: begin
                if (id_muldiv_start && !stall) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    md_cnt_d = md_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            md_cnt_q       <= 8'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with an abstract cycle model checked every cycle.
module tb_hazard_control_unit;

    localparam int MD_LAT = 4;
    localparam int CW     = 4;
    localparam int MAXC   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
    logic          id_uses_rs, id_uses_rt, id_branch, branch_taken;
    logic          id_muldiv_start, id_reads_hilo;
    logic          ex_reg_write, ex_mem_read, mem_mem_read;
    logic          freeze, IF_Flush, id_ex_bubble, md_busy, md_done;
    logic [CW-1:0] stall_cycles, flush_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: remaining busy cycles of the mul/div window, and the two counts.
    int rem  = 0;
    int scnt = 0;
    int fcnt = 0;

    hazard_control_unit #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch(id_branch), .branch_taken(branch_taken),
        .id_muldiv_start(id_muldiv_start), .id_reads_hilo(id_reads_hilo),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .freeze(freeze), .IF_Flush(IF_Flush), .id_ex_bubble(id_ex_bubble),
        .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic bit hit(input logic [4:0] r);
        return (r != 0) && ((id_uses_rs && r == id_rs) || (id_uses_rt && r == id_rt));
    endfunction

    function automatic bit m_stall();
        bit lu, br, md;
        lu = ex_mem_read && hit(ex_rd);
        br = id_branch && ((ex_reg_write && hit(ex_rd)) || (mem_mem_read && hit(mem_rd)));
        md = (rem > 0) && (id_reads_hilo || id_muldiv_start);
        return lu || br || md;
    endfunction

    function automatic bit m_freeze();
        return !reset && m_stall();
    endfunction

    function automatic bit m_flush();
        return !reset && id_branch && branch_taken && !m_stall();
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            rem  <= 0;
            scnt <= 0;
            fcnt <= 0;
        end else begin
            if (rem > 0) rem <= rem - 1;
            else if (id_muldiv_start && !m_stall()) rem <= MD_LAT;
            if (m_freeze() && scnt < MAXC) scnt <= scnt + 1;
            if (m_flush() && fcnt < MAXC) fcnt <= fcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_freeze", 32'(freeze), 32'(m_freeze()));
            chk("cmp_bubble", 32'(id_ex_bubble), 32'(m_freeze()));
            chk("cmp_flush", 32'(IF_Flush), 32'(m_flush()));
            chk("cmp_md_busy", 32'(md_busy), 32'(rem > 0));
            chk("cmp_md_done", 32'(md_done), 32'(rem == 1 && !reset));
            chk("cmp_stall_cycles", 32'(stall_cycles), scnt);
            chk("cmp_flush_count", 32'(flush_count), fcnt);
            chk("cmp_not_both", 32'(freeze && IF_Flush), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_branch = 0; branch_taken = 0;
        id_muldiv_start = 0; id_reads_hilo = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        tick();
        chk_en = 1'b1;
        // Reset forces hazard outputs low even with a live load-use pattern.
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        @(negedge clk);
        chk("rst_freeze", 32'(freeze), 0);
        chk("rst_bubble", 32'(id_ex_bubble), 0);
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_stall_cycles", 32'(stall_cycles), 0);
        chk("rst_flush_count", 32'(flush_count), 0);
        tick();
        reset = 1'b0;

        // Load-use for one cycle.
        @(negedge clk);
        chk("lu_freeze", 32'(freeze), 1);
        chk("lu_bubble", 32'(id_ex_bubble), 1);
        chk("lu_cnt_before", 32'(stall_cycles), 0);
        tick();
        clear_in();
        @(negedge clk);
        chk("lu_freeze_gone", 32'(freeze), 0);
        chk("lu_cnt_after", 32'(stall_cycles), 1);

        // Register zero and an rt match that is not actually read.
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        @(negedge clk);
        chk("r0_freeze", 32'(freeze), 0);
        tick();
        clear_in();
        ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 0;
        @(negedge clk);
        chk("rt_unused_freeze", 32'(freeze), 0);
        tick();

        // Branch operand hazard from EX, then resolution with a taken branch.
        clear_in();
        id_branch = 1; branch_taken = 1; ex_reg_write = 1; ex_rd = 3; id_rt = 3; id_uses_rt = 1;
        @(negedge clk);
        chk("br_freeze", 32'(freeze), 1);
        chk("br_flush_held", 32'(IF_Flush), 0);
        tick();
        ex_reg_write = 0;
        @(negedge clk);
        chk("br_flush", 32'(IF_Flush), 1);
        chk("br_freeze_gone", 32'(freeze), 0);
        tick();
        clear_in();
        @(negedge clk);
        chk("br_flush_count", 32'(flush_count), 1);
        chk("br_stall_count", 32'(stall_cycles), 2);

        // Branch versus a load in MEM; the same load ahead of a non-branch is harmless.
        id_branch = 1; mem_mem_read = 1; mem_rd = 9; id_rs = 9; id_uses_rs = 1;
        @(negedge clk);
        chk("br_mem_freeze", 32'(freeze), 1);
        tick();
        id_branch = 0;
        @(negedge clk);
        chk("nobr_mem_freeze", 32'(freeze), 0);
        tick();
        clear_in();

        // Mul/div window with mfhi waiting and a taken branch held across it.
        id_muldiv_start = 1;
        @(negedge clk);
        chk("md_start_busy", 32'(md_busy), 0);
        tick();
        id_muldiv_start = 0; id_reads_hilo = 1; id_branch = 1; branch_taken = 1;
        for (int k = 1; k <= MD_LAT; k++) begin
            @(negedge clk);
            chk("md_busy_win", 32'(md_busy), 1);
            chk("md_hilo_freeze", 32'(freeze), 1);
            chk("md_no_flush", 32'(IF_Flush), 0);
            chk("md_done_win", 32'(md_done), (k == MD_LAT) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        chk("md_after_busy", 32'(md_busy), 0);
        chk("md_after_freeze", 32'(freeze), 0);
        chk("md_after_flush", 32'(IF_Flush), 1);
        tick();
        clear_in();

        // Back-to-back starts: each accepted only from IDLE.
        id_muldiv_start = 1;
        repeat (12) tick();
        clear_in();
        repeat (6) tick();

        // Reset on the second busy cycle.
        id_muldiv_start = 1;
        tick();
        id_muldiv_start = 0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_busy_held", 32'(md_busy), 1);
        chk("mrst_no_done", 32'(md_done), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 32'(md_busy), 0);
        chk("mrst_stall_cnt", 32'(stall_cycles), 0);
        chk("mrst_flush_cnt", 32'(flush_count), 0);
        for (int k = 0; k < MD_LAT; k++) begin
            tick();
            @(negedge clk);
            chk("mrst_done_quiet", 32'(md_done), 0);
        end
        tick();

        // Saturation of both counters.
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        repeat (20) tick();
        clear_in();
        @(negedge clk);
        chk("sat_stall", 32'(stall_cycles), MAXC);
        id_branch = 1; branch_taken = 1;
        repeat (20) tick();
        clear_in();
        @(negedge clk);
        chk("sat_flush", 32'(flush_count), MAXC);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer side of the pipeline-register control interface: it generates freeze (hold PC and IF/ID), IF_Flush (zero the IF/ID instruction) and id_ex_bubble (zero the ID/EX control fields).
- Detects load-use and branch-operand hazards from ID-stage operands versus EX/MEM destinations.
- Sequences a multi-cycle multiply/divide busy window and keeps saturating stall/flush performance counters.

Parameters:
MD_LATENCY, 8, cycles the mul/div unit is busy after a start; legal range 2..255
CNT_W, 32, width of performance counters

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_branch  input  1  ID instruction is beq/bne (compared in ID)
branch_taken  input  1  ID comparator result, valid when id_branch
id_muldiv_start  input  1  ID instruction is mult/div
id_reads_hilo  input  1  ID instruction is mfhi/mflo
ex_rd  input  5  destination register of instruction in EX
ex_reg_write  input  1  EX instruction writes register file
ex_mem_read  input  1  EX instruction is a load
mem_rd  input  5  destination register of instruction in MEM
mem_mem_read  input  1  MEM instruction is a load
freeze  output  1  hold PC and IF/ID this cycle
IF_Flush  output  1  clear IF/ID instruction at next edge
id_ex_bubble  output  1  insert NOP controls into ID/EX at next edge
md_busy  output  1  mul/div window active
md_done  output  1  one-cycle pulse on the last busy cycle
stall_cycles  output  CNT_W  count of cycles with freeze=1
flush_count  output  CNT_W  count of cycles with IF_Flush=1

Behaviour:
Interface and reset:
- Single clock domain clk; reset synchronous, active-high, sampled on the rising edge.
- Reset values: state=IDLE, counter=0, md_busy=0, md_done=0, stall_cycles=0, flush_count=0.
- While reset=1, freeze, IF_Flush and id_ex_bubble are forced to 0.

Hazard terms (combinational, current cycle; register 0 never matches):
- match(r) = r!=0 && ((id_uses_rs && r==id_rs) || (id_uses_rt && r==id_rt)).
- load_use = ex_mem_read && match(ex_rd).
- br_stall = id_branch && ((ex_reg_write && match(ex_rd)) || (mem_mem_read && match(mem_rd))).
- md_stall = md_busy && (id_reads_hilo || id_muldiv_start).
- stall = load_use || br_stall || md_stall.

Outputs (zero latency, combinational from inputs plus state):
- freeze = stall; id_ex_bubble = stall.
- IF_Flush = id_branch && branch_taken && !stall. When stalled, the flush waits for the branch's resolution cycle.
- freeze and IF_Flush are never both 1.

FSM, states IDLE and MD_BUSY:
- IDLE: id_muldiv_start && !stall -> MD_BUSY, counter <= MD_LATENCY-1.
- MD_BUSY: md_busy=1; counter decrements each cycle.
  - When counter==0: md_done=1 this cycle, and next state is IDLE.
  - A new id_muldiv_start in MD_BUSY is stalled by md_stall. It is accepted only in IDLE, so back-to-back mul/div costs a full window plus the IDLE cycle.
- Reset in MD_BUSY returns to IDLE immediately; no md_done pulse.

Counters:
- Each cycle, stall_cycles increments when freeze=1 and flush_count increments when IF_Flush=1.
- Both saturate at all-ones and never wrap.
- Both update only when reset=0.

Simultaneous events:
- load_use and br_stall together: a single stall cycle is counted once.
- Branch taken while md_stall: no flush that cycle.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> freeze=1 and id_ex_bubble=1 for exactly 1 cycle; stall_cycles goes 0->1.
- Register zero: ex_mem_read=1, ex_rd=0, id_rs=0, id_uses_rs=1 -> freeze=0.
- Branch hazards:
  - id_branch=1 with ex_reg_write=1, ex_rd=3, id_rt=3, id_uses_rt=1 -> freeze=1 and IF_Flush=0.
  - Next cycle with the hazard gone and branch_taken=1 -> IF_Flush=1, flush_count=1.
- Mul/div window, MD_LATENCY=4:
  - Pulse id_muldiv_start -> md_busy=1 for 4 cycles, md_done=1 on the 4th.
  - id_reads_hilo=1 held -> freeze=1 on those 4 cycles, then 0 on the following cycle.
- Reset mid-operation: assert reset on the 2nd busy cycle -> next cycle md_busy=0, md_done never pulses, counters=0.
- Saturation: use CNT_W=4 and hold a load-use hazard 20 cycles -> stall_cycles stops at 15.
